// File: rtl/envelope_gate.sv
// Noise gate with hysteresis: attack/open/hold/release FSM ramping a gain
// register that scales the envelope-aligned audio sample each clock.
module envelope_gate #(
  parameter int SAMPLE_WIDTH = 24,
  parameter int GAIN_WIDTH   = 16,
  parameter int HOLD_WIDTH   = 16
) (
  input  logic                    sample_clock,
  input  logic                    rst,
  input  logic [SAMPLE_WIDTH-1:0] env_in,
  input  logic [SAMPLE_WIDTH-1:0] audio_in,
  input  logic [SAMPLE_WIDTH-1:0] thresh_open,
  input  logic [SAMPLE_WIDTH-1:0] thresh_close,
  input  logic [HOLD_WIDTH-1:0]   hold_len,
  input  logic [GAIN_WIDTH-1:0]   attack_step,
  input  logic [GAIN_WIDTH-1:0]   release_step,
  output logic [SAMPLE_WIDTH-1:0] audio_out,
  output logic [GAIN_WIDTH-1:0]   gain,
  output logic [2:0]              gate_state,
  output logic                    gate_open
);
  typedef enum logic [2:0] {
    CLOSED  = 3'd0,
    ATTACK  = 3'd1,
    OPEN    = 3'd2,
    HOLD    = 3'd3,
    RELEASE = 3'd4
  } state_t;

  localparam logic [GAIN_WIDTH-1:0] UNITY = GAIN_WIDTH'(1) << (GAIN_WIDTH-1);

  state_t                  state, state_nxt;
  logic [GAIN_WIDTH-1:0]   gain_nxt;
  logic [HOLD_WIDTH-1:0]   cnt, cnt_nxt;
  logic [GAIN_WIDTH:0]     sum;
  logic                    open_hit, close_hit;
  logic signed [SAMPLE_WIDTH+GAIN_WIDTH:0] prod, scaled;

  assign open_hit   = env_in >= thresh_open;
  assign close_hit  = env_in < thresh_close;
  assign sum        = {1'b0, gain} + {1'b0, attack_step};
  assign gate_state = state;
  assign gate_open  = (state != CLOSED);

  // Gain is zero-extended so UNITY stays positive in the signed product.
  assign prod   = $signed(audio_in) * $signed({1'b0, gain});
  assign scaled = prod >>> (GAIN_WIDTH-1);

  always_comb begin
    state_nxt = state;
    gain_nxt  = gain;
    cnt_nxt   = cnt;
    case (state)
      CLOSED: begin
        gain_nxt = '0;
        if (open_hit) state_nxt = ATTACK;
      end
      ATTACK: begin
        if (close_hit) begin
          state_nxt = RELEASE;
        end else if (attack_step == '0 || sum >= {1'b0, UNITY}) begin
          gain_nxt  = UNITY;
          state_nxt = OPEN;
        end else begin
          gain_nxt = sum[GAIN_WIDTH-1:0];
        end
      end
      OPEN: begin
        gain_nxt = UNITY;
        if (close_hit) begin
          if (hold_len != '0) begin
            state_nxt = HOLD;
            cnt_nxt   = hold_len;
          end else begin
            state_nxt = RELEASE;
          end
        end
      end
      HOLD: begin
        gain_nxt = UNITY;
        if (open_hit) begin
          state_nxt = OPEN;
          cnt_nxt   = '0;
        end else if (cnt == HOLD_WIDTH'(1)) begin
          state_nxt = RELEASE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt - HOLD_WIDTH'(1);
        end
      end
      RELEASE: begin
        if (open_hit) begin
          state_nxt = ATTACK;
        end else if (release_step == '0 || gain <= release_step) begin
          gain_nxt  = '0;
          state_nxt = CLOSED;
        end else begin
          gain_nxt = gain - release_step;
        end
      end
      default: begin
        state_nxt = CLOSED;
        gain_nxt  = '0;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge sample_clock) begin
    if (rst) begin
      state     <= CLOSED;
      gain      <= '0;
      cnt       <= '0;
      audio_out <= '0;
    end else begin
      state     <= state_nxt;
      gain      <= gain_nxt;
      cnt       <= cnt_nxt;
      audio_out <= scaled[SAMPLE_WIDTH-1:0];
    end
  end
endmodule

// File: tb/tb_envelope_gate.sv
// Directed bench for envelope_gate: hand-computed state/gain/audio after each edge.
module tb_envelope_gate;
  logic        sample_clock = 1'b0;
  logic        rst;
  logic [23:0] env_in, audio_in, thresh_open, thresh_close;
  logic [15:0] hold_len, attack_step, release_step;
  logic [23:0] audio_out;
  logic [15:0] gain;
  logic [2:0]  gate_state;
  logic        gate_open;

  int compared = 0;
  int mismatched = 0;

  envelope_gate dut (
    .sample_clock(sample_clock), .rst(rst), .env_in(env_in), .audio_in(audio_in),
    .thresh_open(thresh_open), .thresh_close(thresh_close), .hold_len(hold_len),
    .attack_step(attack_step), .release_step(release_step), .audio_out(audio_out),
    .gain(gain), .gate_state(gate_state), .gate_open(gate_open)
  );

  always #5 sample_clock = ~sample_clock;

  task automatic tick();
    @(posedge sample_clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_sg(input string tag, input logic [2:0] st, input logic [15:0] g);
    chk({tag, ".state"}, {29'd0, gate_state}, {29'd0, st});
    chk({tag, ".gain"}, {16'd0, gain}, {16'd0, g});
  endtask

  initial begin
    rst = 1'b1; env_in = 24'hFFFFFF; audio_in = 24'h7FFFFF;
    thresh_open = 24'h100000; thresh_close = 24'h080000;
    hold_len = 16'd5; attack_step = 16'h2000; release_step = 16'h3000;
    tick(); tick();
    chk_sg("reset", 3'd0, 16'h0000);
    chk("reset.audio", {8'd0, audio_out}, 32'h0);
    chk("reset.open", {31'd0, gate_open}, 32'd0);

    rst = 1'b0; env_in = 24'h000000; audio_in = 24'h100000;
    tick();
    chk_sg("post_reset", 3'd0, 16'h0000);

    // Attack ramp
    env_in = 24'h200000;
    tick(); chk_sg("atk1", 3'd1, 16'h0000);
    chk("atk1.open", {31'd0, gate_open}, 32'd1);
    tick(); chk_sg("atk2", 3'd1, 16'h2000);
    tick(); chk_sg("atk3", 3'd1, 16'h4000);
    tick(); chk_sg("atk4", 3'd1, 16'h6000);
    tick(); chk_sg("atk5", 3'd2, 16'h8000);
    chk("atk5.audio", {8'd0, audio_out}, 32'h0C0000);
    tick(); chk("unity.audio", {8'd0, audio_out}, 32'h100000);

    // Hold of 5 cycles then release ramp to saturation
    env_in = 24'h010000;
    for (int i = 0; i < 5; i++) begin
      tick(); chk_sg($sformatf("hold%0d", i), 3'd3, 16'h8000);
    end
    tick(); chk_sg("hold_exit", 3'd4, 16'h8000);
    env_in = 24'h000000;
    tick(); chk_sg("rel1", 3'd4, 16'h5000);
    tick(); chk_sg("rel2", 3'd4, 16'h2000);
    tick(); chk_sg("rel3", 3'd0, 16'h0000);

    // Instant attack, then hold_len=0 skips HOLD
    env_in = 24'h200000; attack_step = 16'h0000;
    tick(); chk_sg("inst_atk1", 3'd1, 16'h0000);
    tick(); chk_sg("inst_atk2", 3'd2, 16'h8000);
    hold_len = 16'd0; env_in = 24'h010000;
    tick(); chk_sg("nohold", 3'd4, 16'h8000);
    env_in = 24'h000000;
    tick(); chk_sg("rel_part", 3'd4, 16'h5000);

    // Reattack from partial release gain
    env_in = 24'h200000; attack_step = 16'h2000;
    tick(); chk_sg("reatk1", 3'd1, 16'h5000);
    tick(); chk_sg("reatk2", 3'd1, 16'h7000);
    tick(); chk_sg("reatk3", 3'd2, 16'h8000);

    // Retrigger during third HOLD cycle
    hold_len = 16'd5; env_in = 24'h010000;
    tick(); chk_sg("rtg1", 3'd3, 16'h8000);
    tick(); chk_sg("rtg2", 3'd3, 16'h8000);
    tick(); chk_sg("rtg3", 3'd3, 16'h8000);
    env_in = 24'h200000;
    tick(); chk_sg("rtg_open", 3'd2, 16'h8000);
    tick(); chk_sg("rtg_stay", 3'd2, 16'h8000);

    // Negative scaling at half gain
    hold_len = 16'd0; env_in = 24'h010000;
    tick(); chk_sg("neg_rel", 3'd4, 16'h8000);
    release_step = 16'h4000;
    tick(); chk_sg("neg_half", 3'd4, 16'h4000);
    audio_in = 24'hFFFFFD; env_in = 24'h000000;
    tick(); chk_sg("neg_close", 3'd0, 16'h0000);
    chk("neg.audio", {8'd0, audio_out}, 32'hFFFFFE);

    // Unity bit-exact on the most negative sample
    env_in = 24'h200000; attack_step = 16'h0000;
    tick(); tick(); chk_sg("u_open", 3'd2, 16'h8000);
    audio_in = 24'h800000;
    tick(); chk("u_min.audio", {8'd0, audio_out}, 32'h800000);
    audio_in = 24'h123456;
    tick(); chk("u_pat.audio", {8'd0, audio_out}, 32'h123456);

    // Instant release
    env_in = 24'h010000; release_step = 16'h0000;
    tick(); chk_sg("irel1", 3'd4, 16'h8000);
    env_in = 24'h000000;
    tick(); chk_sg("irel2", 3'd0, 16'h0000);

    // Reset mid-ramp leaves no residue
    env_in = 24'h200000; attack_step = 16'h2000;
    tick(); tick(); tick();
    chk_sg("pre_rst", 3'd1, 16'h4000);
    rst = 1'b1;
    tick(); chk_sg("mid_rst", 3'd0, 16'h0000);
    chk("mid_rst.audio", {8'd0, audio_out}, 32'h0);
    rst = 1'b0;
    tick(); chk_sg("rst_atk", 3'd1, 16'h0000);
    tick(); chk_sg("rst_atk2", 3'd1, 16'h2000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/envelope_gate.md
Name: envelope_gate

Overview:
- Noise-gate controller directly downstream of the 8-tap moving-average envelope stage.
- Compares the smoothed envelope against open/close thresholds with hysteresis.
- Runs an attack/open/hold/release state machine that ramps a gain register.
- Applies the gain to the time-aligned audio sample, one sample per clock at 96 kHz.

Parameters:
SAMPLE_WIDTH, 24, width of envelope, audio and threshold samples
GAIN_WIDTH, 16, gain register width; unity gain UNITY = 2^(GAIN_WIDTH-1) (0x8000 at default)
HOLD_WIDTH, 16, width of hold counter and hold_len

Ports:
sample_clock  in   1             sole clock; one sample per rising edge
rst           in   1             synchronous, active-high reset
env_in        in   SAMPLE_WIDTH  unsigned envelope from the averaging stage
audio_in      in   SAMPLE_WIDTH  signed two's-complement audio, already aligned to env_in
thresh_open   in   SAMPLE_WIDTH  unsigned open threshold
thresh_close  in   SAMPLE_WIDTH  unsigned close threshold
hold_len      in   HOLD_WIDTH    hold time in samples
attack_step   in   GAIN_WIDTH    gain increment per ATTACK cycle
release_step  in   GAIN_WIDTH    gain decrement per RELEASE cycle
audio_out     out  SAMPLE_WIDTH  signed gated audio, registered
gain          out  GAIN_WIDTH    current gain register, 0..UNITY
gate_state    out  3             CLOSED=0, ATTACK=1, OPEN=2, HOLD=3, RELEASE=4
gate_open     out  1             high whenever gate_state != CLOSED

Behaviour:
- Reset: all state changes occur only on the rising edge of sample_clock, including reset. While rst is high at an edge:
  - state <= CLOSED, gain <= 0, hold counter <= 0, audio_out <= 0.
  - gate_open is 0.
  - Reset mid-ramp or mid-hold aborts the ramp or hold with no residue.
- No valid handshake: every edge consumes one sample. All config inputs are sampled every cycle with no shadowing.
- Comparisons are unsigned:
  - open_hit = env_in >= thresh_open.
  - close_hit = env_in < thresh_close.
- Zero step sizes: attack_step = 0 is an instant attack (gain jumps to UNITY). release_step = 0 is an instant release (gain jumps to 0).
- CLOSED: gain held at 0. open_hit -> ATTACK; gain is unchanged on that edge.
- ATTACK, evaluated in priority order:
  1. close_hit -> RELEASE, gain unchanged.
  2. gain + attack_step >= UNITY -> gain <= UNITY, -> OPEN.
  3. Otherwise gain <= gain + attack_step.
  - The sum is computed GAIN_WIDTH+1 wide, so there is no wrap.
- OPEN: gain held at UNITY. On close_hit:
  - hold_len != 0 -> HOLD, counter <= hold_len.
  - hold_len == 0 -> RELEASE directly.
- HOLD: gain held at UNITY. Evaluated in priority order:
  1. open_hit -> OPEN, counter <= 0.
  2. counter == 1 -> RELEASE.
  3. Otherwise counter <= counter - 1.
  - Net effect: exactly hold_len cycles in HOLD absent a retrigger.
  - A hold_len change during HOLD does not reload the counter.
- RELEASE: evaluated in priority order:
  1. open_hit -> ATTACK, ramping up from the current gain.
  2. gain <= release_step -> gain <= 0, -> CLOSED.
  3. Otherwise gain <= gain - release_step. Gain never underflows.
- Misconfiguration (thresh_close > thresh_open): no special handling; the rules above apply as written, and open_hit priority prevents lockup.
- Illegal state encodings (5-7) -> CLOSED, gain <= 0 on the next edge.
- Audio path:
  - audio_out <= (audio_in * {0, gain}) >>> (GAIN_WIDTH-1). The gain operand is zero-extended to signed; the product is SAMPLE_WIDTH+GAIN_WIDTH+1 bits.
  - Arithmetic shift rounds toward negative infinity; keep the low SAMPLE_WIDTH bits. No overflow is possible since gain <= UNITY.
  - Uses the gain register value before this edge's update.
  - Latency: audio_out at edge n+1 = audio_in at edge n scaled by gain at edge n.
  - At UNITY, audio_out equals audio_in delayed by exactly one cycle, bit-exact.
- gain and gate_state are direct register outputs; gate_open is decoded combinationally from state.

Test Plan:
- Reset: rst=1 for 2 edges with env_in=0xFFFFFF, audio_in=0x7FFFFF -> gain=0, audio_out=0, gate_state=0, gate_open=0; first edge after release still CLOSED until open_hit is sampled.
- Attack ramp: thresh_open=0x100000, thresh_close=0x080000, attack_step=0x2000, env_in=0x200000, audio_in=0x100000 from CLOSED:
  - edge 1 -> ATTACK, gain 0.
  - gain goes 0x2000, 0x4000, 0x6000, then 0x8000 with state OPEN on the 4th ATTACK edge.
  - audio_out=0x100000 one edge later.
- Hold timing: in OPEN, hold_len=5, env_in drops to 0x010000 -> exactly 5 cycles in HOLD with gain=0x8000, then RELEASE; repeat with hold_len=0 -> OPEN goes directly to RELEASE.
- Retrigger: during HOLD cycle 3, env_in=0x200000 -> state OPEN next edge, gain stays 0x8000, and there is no RELEASE cycle.
- Release saturation: from gain=0x8000, release_step=0x3000, env_in=0 -> gain 0x5000, 0x2000, then 0x0000 with state CLOSED; never 0xF000. Variant: open_hit at gain 0x5000 -> ATTACK resumes from 0x5000.
- Negative scaling: gain=0x4000, audio_in=0xFFFFFD (-3) -> audio_out=0xFFFFFE (-2). gain=0x8000, audio_in=0x800000 -> audio_out=0x800000.
